// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache array: address-field helpers
// and the flush engine state encoding.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WB,
    DONE
  } flush_state_e;

  // Address layout, LSB first: 2-bit byte offset | word | set | tag.
  function automatic int set_lsb(input int words_per_block);
    return 2 + $clog2(words_per_block);
  endfunction

  function automatic int tag_lsb(input int num_sets, input int words_per_block);
    return set_lsb(words_per_block) + $clog2(num_sets);
  endfunction

  function automatic int tag_size(input int addr_size, input int num_sets,
                                  input int words_per_block);
    return addr_size - tag_lsb(num_sets, words_per_block);
  endfunction

endpackage

// File: rtl/cache_array_plru_plru_tree.sv
// Tree pseudo-LRU: a node bit of 0 points at its left subtree, 1 at its right.
// Heap layout: node n has children 2n+1 and 2n+2.
module plru_tree #(
  parameter int  NUM_WAYS = 4,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits,
  input  logic [WAY_W-1:0]    way,
  output logic [NUM_WAYS-2:0] bits_next,
  output logic [WAY_W-1:0]    victim
);

  int                  node;
  logic [NUM_WAYS-2:0] shifted;
  logic                dir;

  // NOTE: every variable driven here gets a value before any branch reads or
  // skips it; otherwise the synthesiser would infer a latch to hold it.
  always_comb begin
    bits_next = bits;
    for (int l = 0; l < WAY_W; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        if (int'(way >> (WAY_W - l)) == k) begin
          bits_next[(1 << l) - 1 + k] = ~way[WAY_W-1-l];
        end
      end
    end

    victim  = '0;
    node    = 0;
    shifted = '0;
    dir     = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      shifted           = bits >> node;
      dir               = shifted[0];
      victim[WAY_W-1-l] = dir;
      node              = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/cache_array_plru.sv
// Set-associative line store with byte-enabled writes, dirty bits, tree PLRU and
// a flush engine. Optional hit/miss counters are enabled by CACHE_STATS_EN.
module cache_array_plru
  import cache_pkg::*;
#(
  parameter int  ADDR_SIZE       = 32,
  parameter int  NUM_SETS        = 16,
  parameter int  NUM_WAYS        = 4,
  parameter int  WORDS_PER_BLOCK = 4,
  localparam int TAG_W           = tag_size(ADDR_SIZE, NUM_SETS, WORDS_PER_BLOCK),
  localparam int WAY_W           = $clog2(NUM_WAYS),
  localparam int BLOCK_W         = 32 * WORDS_PER_BLOCK
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lookup_valid,
  input  logic [ADDR_SIZE-1:0] lookup_addr,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_W-1:0]     resp_way,
  output logic [31:0]          resp_rdata,
  output logic                 victim_valid,
  output logic                 victim_dirty,
  output logic [TAG_W-1:0]     victim_tag,
  input  logic                 wr_en,
  input  logic [WAY_W-1:0]     wr_way,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [3:0]           wr_be,
  input  logic [31:0]          wr_data,
  input  logic                 fill_en,
  input  logic [WAY_W-1:0]     fill_way,
  input  logic [ADDR_SIZE-1:0] fill_addr,
  input  logic [BLOCK_W-1:0]   fill_data,
  input  logic                 flush_req,
  output logic                 busy,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ADDR_SIZE-1:0] wb_addr,
  output logic [BLOCK_W-1:0]   wb_data,
  output logic                 flush_done
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int WORD_W    = $clog2(WORDS_PER_BLOCK);
  localparam int WORD_IW   = (WORD_W > 0) ? WORD_W : 1;
  localparam int NUM_LINES = NUM_SETS * NUM_WAYS;
  localparam int IDX_W     = SET_W + WAY_W;
  localparam int SET_LSB   = set_lsb(WORDS_PER_BLOCK);
  localparam int TAG_LSB   = tag_lsb(NUM_SETS, WORDS_PER_BLOCK);

  typedef struct packed {
    logic [BLOCK_W-1:0] data;
    logic [TAG_W-1:0]   tag;
    logic               valid;
    logic               dirty;
  } line_t;

  function automatic logic [SET_W-1:0] set_of(input logic [ADDR_SIZE-1:0] a);
    return SET_W'(a >> SET_LSB);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_SIZE-1:0] a);
    return TAG_W'(a >> TAG_LSB);
  endfunction

  function automatic logic [WORD_IW-1:0] word_of(input logic [ADDR_SIZE-1:0] a);
    return WORD_IW'((a >> 2) & ADDR_SIZE'(WORDS_PER_BLOCK - 1));
  endfunction

  // Line index is {set, way}, so the flush walk visits every way of a set in turn.
  logic [BLOCK_W-1:0]  data_q  [NUM_LINES];
  logic [TAG_W-1:0]    tag_q   [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

  flush_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            flush_inv;
  line_t           fl_line;

  logic lk_act, wr_act, fill_act;
  assign lk_act   = lookup_valid & ~busy;
  assign wr_act   = wr_en & ~busy;
  assign fill_act = fill_en & ~busy;

  // Lookup path: reads pre-update state; the result is registered below.
  logic [SET_W-1:0]    lk_set;
  logic [TAG_W-1:0]    lk_tag;
  logic [WORD_IW-1:0]  lk_word;
  logic                lk_hit, lk_any_inv;
  logic [WAY_W-1:0]    lk_hit_way, lk_inv_way, lk_victim, lk_way;
  logic [IDX_W-1:0]    lk_idx;
  line_t               lk_line;
  logic [NUM_WAYS-2:0] lk_bits_next;

  assign lk_set  = set_of(lookup_addr);
  assign lk_tag  = tag_of(lookup_addr);
  assign lk_word = word_of(lookup_addr);

  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    lk_any_inv = 1'b0;
    lk_inv_way = '0;
    // Walk downward so the lowest-index match or invalid way is the last written.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[{lk_set, WAY_W'(w)}] && tag_q[{lk_set, WAY_W'(w)}] == lk_tag) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (!valid_q[{lk_set, WAY_W'(w)}]) begin
        lk_any_inv = 1'b1;
        lk_inv_way = WAY_W'(w);
      end
    end
    lk_way        = lk_hit ? lk_hit_way : (lk_any_inv ? lk_inv_way : lk_victim);
    lk_idx        = {lk_set, lk_way};
    lk_line.data  = data_q[lk_idx];
    lk_line.tag   = tag_q[lk_idx];
    lk_line.valid = valid_q[lk_idx];
    lk_line.dirty = dirty_q[lk_idx];
  end

  // Write and fill decode.
  logic [SET_W-1:0]   wr_set, fill_set;
  logic [WORD_IW-1:0] wr_word;
  logic [IDX_W-1:0]   widx, fidx;
  logic [31:0]        wr_base, wr_merged;

  assign wr_set   = set_of(wr_addr);
  assign wr_word  = word_of(wr_addr);
  assign fill_set = set_of(fill_addr);
  assign widx     = {wr_set, wr_way};
  assign fidx     = {fill_set, fill_way};

  always_comb begin
    wr_base = (fill_act && fidx == widx) ? fill_data[int'(wr_word)*32 +: 32]
                                         : data_q[widx][int'(wr_word)*32 +: 32];
    for (int b = 0; b < 4; b++) begin
      wr_merged[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : wr_base[8*b +: 8];
    end
  end

  // PLRU updates chain lookup -> fill -> write so a shared set sees all three.
  logic [NUM_WAYS-2:0] fill_bits_in, fill_bits_next, wr_bits_in, wr_bits_next;
  logic [WAY_W-1:0]    fill_victim_unused, wr_victim_unused;

  always_comb begin
    fill_bits_in = (lk_act && lk_hit && lk_set == fill_set) ? lk_bits_next : plru_q[fill_set];
    if (fill_act && fill_set == wr_set) begin
      wr_bits_in = fill_bits_next;
    end else if (lk_act && lk_hit && lk_set == wr_set) begin
      wr_bits_in = lk_bits_next;
    end else begin
      wr_bits_in = plru_q[wr_set];
    end
  end

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_lookup (
    .bits      (plru_q[lk_set]),
    .way       (lk_hit_way),
    .bits_next (lk_bits_next),
    .victim    (lk_victim)
  );

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_fill (
    .bits      (fill_bits_in),
    .way       (fill_way),
    .bits_next (fill_bits_next),
    .victim    (fill_victim_unused)
  );

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_write (
    .bits      (wr_bits_in),
    .way       (wr_way),
    .bits_next (wr_bits_next),
    .victim    (wr_victim_unused)
  );

  // Control state: valid/dirty/PLRU, response strobe and flush engine.
  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      dirty_q    <= '0;
      for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      resp_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      resp_valid <= lk_act;
      if (lk_act && lk_hit) plru_q[lk_set] <= lk_bits_next;
      if (fill_act) begin
        plru_q[fill_set] <= fill_bits_next;
        valid_q[fidx]    <= 1'b1;
        dirty_q[fidx]    <= 1'b0;
      end
      if (wr_act) begin
        plru_q[wr_set] <= wr_bits_next;
        dirty_q[widx]  <= 1'b1;
      end
      if (flush_inv) begin
        valid_q[idx_q] <= 1'b0;
        dirty_q[idx_q] <= 1'b0;
      end
    end
  end

  // NOTE: data, tags and response payload carry no reset: valid bits and
  // resp_valid qualify them, and resetting a RAM array forbids RAM mapping.
  always_ff @(posedge clk) begin
    if (fill_act) begin
      data_q[fidx] <= fill_data;
      tag_q[fidx]  <= tag_of(fill_addr);
    end
    if (wr_act) data_q[widx][int'(wr_word)*32 +: 32] <= wr_merged;
    if (lk_act) begin
      resp_hit     <= lk_hit;
      resp_way     <= lk_way;
      resp_rdata   <= lk_line.data[int'(lk_word)*32 +: 32];
      victim_valid <= lk_line.valid;
      victim_dirty <= lk_line.dirty;
      victim_tag   <= lk_line.tag;
    end
  end

  // Flush engine next state.
  always_comb begin
    fl_line.data  = data_q[idx_q];
    fl_line.tag   = tag_q[idx_q];
    fl_line.valid = valid_q[idx_q];
    fl_line.dirty = dirty_q[idx_q];
    state_d       = state_q;
    idx_d         = idx_q;
    flush_inv     = 1'b0;
    unique case (state_q)
      IDLE: if (flush_req) begin
        state_d = SCAN;
        idx_d   = '0;
      end
      SCAN, WB: begin
        if (state_q == SCAN && fl_line.valid && fl_line.dirty) begin
          state_d = WB;
        end else if (state_q == SCAN || wb_ready) begin
          flush_inv = 1'b1;
          if (idx_q == IDX_W'(NUM_LINES - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign wb_valid   = (state_q == WB);
  assign flush_done = (state_q == DONE);
  assign wb_addr    = {fl_line.tag, idx_q[IDX_W-1:WAY_W], {SET_LSB{1'b0}}};
  assign wb_data    = fl_line.data;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid) begin
      if (resp_hit && hit_count != '1) hit_count <= hit_count + 1'b1;
      if (!resp_hit && miss_count != '1) miss_count <= miss_count + 1'b1;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{lookup_addr[1:0], wr_addr[1:0], wr_addr[ADDR_SIZE-1:TAG_LSB],
                         fill_addr[SET_LSB-1:0], fill_victim_unused, wr_victim_unused};

endmodule
